// File: rtl/a23_gc_pkg.sv
// rtl/a23_gc_pkg.sv - shared word width, region bases and loader FSM encoding
package a23_gc_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_LOAD_P = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_G = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD_E = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

    // Region base addresses as seen by the core's memory map
    localparam logic [WORD_W-1:0] BASE_CODE   = 32'h00 << 24;
    localparam logic [WORD_W-1:0] BASE_G      = 32'h01 << 24;
    localparam logic [WORD_W-1:0] BASE_E      = 32'h02 << 24;
    localparam logic [WORD_W-1:0] BASE_CTRL   = 32'h03 << 24;
    localparam logic [WORD_W-1:0] BASE_STATUS = 32'h04 << 24;

    function automatic logic is_load_state(input logic [STATE_W-1:0] s);
        return (s == ST_LOAD_P) || (s == ST_LOAD_G) || (s == ST_LOAD_E);
    endfunction

endpackage

// File: rtl/a23_gc_loader.sv
// rtl/a23_gc_loader.sv - streams code/garbler/evaluator images in, then runs the core under a watchdog
module a23_gc_loader
    import a23_gc_pkg::*;
#(
    parameter int CODE_MEM_SIZE = 64,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int MAX_CYCLES    = 65535
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    input  logic [WORD_W-1:0]                 i_data,
    output logic                              o_ready,
    output logic [CODE_MEM_SIZE*WORD_W-1:0]   p_init,
    output logic [G_MEM_SIZE*WORD_W-1:0]      g_init,
    output logic [E_MEM_SIZE*WORD_W-1:0]      e_init,
    output logic                              o_core_rst,
    input  logic                              i_terminate,
    output logic                              o_done,
    output logic                              o_timeout,
    output logic [31:0]                       o_cycles
);

    localparam int MAX_PG     = (CODE_MEM_SIZE > G_MEM_SIZE) ? CODE_MEM_SIZE : G_MEM_SIZE;
    localparam int MAX_REGION = (MAX_PG > E_MEM_SIZE) ? MAX_PG : E_MEM_SIZE;
    localparam int IDX_W      = $clog2(MAX_REGION) + 1;

    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               last_word;
    logic [31:0]        cycles_inc;

    assign o_ready = is_load_state(state);
    assign accept  = i_valid && o_ready;

    always_comb begin
        last_word = 1'b0;
        case (state)
            ST_LOAD_P: last_word = (idx == IDX_W'(CODE_MEM_SIZE - 1));
            ST_LOAD_G: last_word = (idx == IDX_W'(G_MEM_SIZE - 1));
            ST_LOAD_E: last_word = (idx == IDX_W'(E_MEM_SIZE - 1));
            default:   last_word = 1'b0;
        endcase
    end

    assign cycles_inc = (o_cycles == 32'hFFFF_FFFF) ? o_cycles : o_cycles + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD_P;
            idx        <= '0;
            p_init     <= '0;
            g_init     <= '0;
            e_init     <= '0;
            o_core_rst <= 1'b1;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_cycles   <= '0;
        end else begin
            case (state)
                ST_LOAD_P: begin
                    if (accept) begin
                        for (int k = 0; k < CODE_MEM_SIZE; k++)
                            if (idx == IDX_W'(k)) p_init[k*WORD_W +: WORD_W] <= i_data;
                        if (last_word) begin
                            state <= ST_LOAD_G;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_LOAD_G: begin
                    if (accept) begin
                        for (int k = 0; k < G_MEM_SIZE; k++)
                            if (idx == IDX_W'(k)) g_init[k*WORD_W +: WORD_W] <= i_data;
                        if (last_word) begin
                            state <= ST_LOAD_E;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_LOAD_E: begin
                    if (accept) begin
                        for (int k = 0; k < E_MEM_SIZE; k++)
                            if (idx == IDX_W'(k)) e_init[k*WORD_W +: WORD_W] <= i_data;
                        // Core leaves reset on the same edge that lands the final image word
                        if (last_word) begin
                            state      <= ST_RUN;
                            idx        <= '0;
                            o_core_rst <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    o_cycles <= cycles_inc;
                    // Terminate is checked first so it wins over a coincident watchdog expiry
                    if (i_terminate) begin
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                        o_timeout <= 1'b0;
                    end else if (cycles_inc >= 32'(MAX_CYCLES)) begin
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                        o_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_LOAD_P;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a23_gc_loader.sv
// tb/tb_a23_gc_loader.sv - scoreboard bench for the garbled-circuit loader
module tb_a23_gc_loader;

    localparam int NP = 2;
    localparam int NG = 2;
    localparam int NE = 2;
    localparam int MAXC = 10;

    typedef struct {
        int          region;
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [31:0]       i_data = '0;
    logic              o_ready;
    logic [NP*32-1:0]  p_init;
    logic [NG*32-1:0]  g_init;
    logic [NE*32-1:0]  e_init;
    logic              o_core_rst;
    logic              i_terminate = 1'b0;
    logic              o_done;
    logic              o_timeout;
    logic [31:0]       o_cycles;

    int   vectors = 0;
    int   miscompares = 0;
    int   n_sent = 0;
    exp_t sb[$];

    a23_gc_loader #(
        .CODE_MEM_SIZE(NP),
        .G_MEM_SIZE   (NG),
        .E_MEM_SIZE   (NE),
        .MAX_CYCLES   (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .p_init     (p_init),
        .g_init     (g_init),
        .e_init     (e_init),
        .o_core_rst (o_core_rst),
        .i_terminate(i_terminate),
        .o_done     (o_done),
        .o_timeout  (o_timeout),
        .o_cycles   (o_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_terminate = 1'b0;
        tick(1);
        rst = 1'b0;
        n_sent = 0;
        sb.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        exp_t e;
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_word%0d got=%b want=1", n_sent, o_ready);
        end
        e.region = n_sent / 2;
        e.idx    = n_sent % 2;
        e.data   = d;
        sb.push_back(e);
        n_sent++;
        i_valid = 1'b1;
        i_data  = d;
        tick(1);
        i_valid = 1'b0;
        i_data  = 32'hBAD0_BAD0;
        tick(gap);
    endtask

    task automatic check_images(input string tag);
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.region)
                0:       got = p_init[e.idx*32 +: 32];
                1:       got = g_init[e.idx*32 +: 32];
                default: got = e_init[e.idx*32 +: 32];
            endcase
            vectors++;
            if (got !== e.data) begin
                miscompares++;
                $display("FAIL %s_r%0d_w%0d got=%h want=%h", tag, e.region, e.idx, got, e.data);
            end
        end
    endtask

    task automatic load_six(input logic [31:0] base, input int gap);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (o_core_rst !== 1'b1) begin
                miscompares++;
                $display("FAIL core_rst_before_word%0d got=%b want=1", k, o_core_rst);
            end
            send_word(base + 32'(k), gap);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({p_init, g_init, e_init} !== '0 || o_core_rst !== 1'b1 || o_ready !== 1'b1 ||
            o_done !== 1'b0 || o_timeout !== 1'b0 || o_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state got p=%h g=%h e=%h crst=%b rdy=%b done=%b to=%b cyc=%0d want zeros/crst=1/rdy=1",
                     p_init, g_init, e_init, o_core_rst, o_ready, o_done, o_timeout, o_cycles);
        end
    endtask

    task automatic test_stream();
        logic [63:0] p_snap;
        do_reset();
        load_six(32'h10, 0);
        vectors++;
        if (o_core_rst !== 1'b0 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_release got crst=%b rdy=%b want 0/0", o_core_rst, o_ready);
        end
        vectors++;
        if (p_init !== 64'h00000011_00000010 || g_init !== 64'h00000013_00000012 ||
            e_init !== 64'h00000015_00000014) begin
            miscompares++;
            $display("FAIL stream_pack got p=%h g=%h e=%h", p_init, g_init, e_init);
        end
        check_images("stream");
        p_snap = p_init;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        tick(2);
        i_valid = 1'b0;
        vectors++;
        if (p_init !== p_snap || g_init !== 64'h00000013_00000012 || e_init !== 64'h00000015_00000014) begin
            miscompares++;
            $display("FAIL run_ignore got p=%h g=%h e=%h", p_init, g_init, e_init);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        load_six(32'h10, 1);
        vectors++;
        if (o_core_rst !== 1'b0 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_release got crst=%b rdy=%b want 0/0", o_core_rst, o_ready);
        end
        check_images("toggle");
    endtask

    task automatic test_terminate();
        logic [31:0] cyc_snap;
        do_reset();
        load_six(32'h30, 0);
        tick(3);
        i_terminate = 1'b1;
        tick(1);
        i_terminate = 1'b0;
        cyc_snap = o_cycles;
        vectors++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || !(o_cycles == 32'd3 || o_cycles == 32'd4)) begin
            miscompares++;
            $display("FAIL terminate got done=%b to=%b cyc=%0d want 1/0/3or4", o_done, o_timeout, o_cycles);
        end
        i_terminate = 1'b1;
        tick(5);
        i_terminate = 1'b0;
        vectors++;
        if (o_cycles !== cyc_snap || o_done !== 1'b1 || o_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL done_sticky got cyc=%0d done=%b to=%b want cyc=%0d 1/0", o_cycles, o_done, o_timeout, cyc_snap);
        end
        check_images("term");
    endtask

    task automatic test_watchdog();
        int edges;
        do_reset();
        i_terminate = 1'b1;
        load_six(32'h40, 0);
        i_terminate = 1'b0;
        edges = 0;
        while (o_done !== 1'b1 && edges < 20) begin
            tick(1);
            edges++;
        end
        vectors++;
        if (edges != MAXC) begin
            miscompares++;
            $display("FAIL watchdog_edges got=%0d want=%0d", edges, MAXC);
        end
        vectors++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_cycles !== 32'd10) begin
            miscompares++;
            $display("FAIL watchdog got done=%b to=%b cyc=%0d want 1/1/10", o_done, o_timeout, o_cycles);
        end
        check_images("wdog");
    endtask

    task automatic test_coincide();
        do_reset();
        load_six(32'h50, 0);
        tick(MAXC - 1);
        vectors++;
        if (o_done !== 1'b0 || o_cycles !== 32'd9) begin
            miscompares++;
            $display("FAIL pre_limit got done=%b cyc=%0d want 0/9", o_done, o_cycles);
        end
        i_terminate = 1'b1;
        tick(1);
        i_terminate = 1'b0;
        vectors++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || o_cycles !== 32'd10) begin
            miscompares++;
            $display("FAIL coincide got done=%b to=%b cyc=%0d want 1/0/10", o_done, o_timeout, o_cycles);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        send_word(32'hA0, 0);
        send_word(32'hA1, 0);
        send_word(32'hA2, 0);
        do_reset();
        vectors++;
        if ({p_init, g_init, e_init} !== '0 || o_core_rst !== 1'b1 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_clear got p=%h g=%h crst=%b rdy=%b", p_init, g_init, o_core_rst, o_ready);
        end
        load_six(32'h20, 0);
        vectors++;
        if (p_init !== 64'h00000021_00000020 || g_init !== 64'h00000023_00000022 ||
            e_init !== 64'h00000025_00000024 || o_core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL reload got p=%h g=%h e=%h crst=%b", p_init, g_init, e_init, o_core_rst);
        end
        check_images("reload");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_terminate();
        test_watchdog();
        test_coincide();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
